// File: rtl/bmc_soft_punc_if.sv
// Handshake bundle between the depuncture front end, the branch metric unit and the ACS array.
// Both sides of the unit live here so one interface carries the whole datapath.
interface bmc_soft_punc_if #(
    parameter int CODE_N = 2,
    parameter int SOFT_W = 3,
    parameter int PUNC_P = 1
);
    localparam int MW = SOFT_W + $clog2(CODE_N);
    localparam int PW = (PUNC_P > 1) ? $clog2(PUNC_P) : 1;

    logic                           in_valid;
    logic                           in_ready;
    logic [CODE_N*SOFT_W-1:0]       in_sym;
    logic                           frame_start;
    logic                           out_valid;
    logic                           out_ready;
    logic [(1 << CODE_N)*MW-1:0]    out_bm;
    logic [PW-1:0]                  out_phase;

    modport master (
        output in_valid, in_sym, frame_start, out_ready,
        input  in_ready, out_valid, out_bm, out_phase
    );

    modport slave (
        input  in_valid, in_sym, frame_start, out_ready,
        output in_ready, out_valid, out_bm, out_phase
    );
endinterface

// File: rtl/bmc_soft_punc.sv
// Soft-decision branch metric unit: erases punctured symbols by phase and emits all 2^N
// codeword metrics through a two-stage valid/ready pipeline.
module bmc_soft_punc #(
    parameter int                        CODE_N    = 2,
    parameter int                        SOFT_W    = 3,
    parameter int                        PUNC_P    = 1,
    parameter logic [CODE_N*PUNC_P-1:0]  PUNC_MASK = '1
) (
    input logic            clk,
    input logic            rst_n,
    bmc_soft_punc_if.slave bus
);
    localparam int MW = SOFT_W + $clog2(CODE_N);
    localparam int PW = (PUNC_P > 1) ? $clog2(PUNC_P) : 1;
    localparam int NC = 1 << CODE_N;
    localparam logic [SOFT_W-1:0] SMAX    = '1;
    localparam logic [PW-1:0]     PH_LAST = PW'(PUNC_P - 1);

    logic                           s1_load;
    logic                           s2_load;
    logic                           accept;
    logic [PW-1:0]                  phase_cnt;
    logic [PW-1:0]                  tag;
    logic [CODE_N-1:0]              keep;
    logic                           v1;
    logic                           v2;
    logic [PW-1:0]                  ph1;
    logic [PW-1:0]                  ph2;
    logic [CODE_N-1:0][SOFT_W-1:0]  d0_n;
    logic [CODE_N-1:0][SOFT_W-1:0]  d1_n;
    logic [CODE_N-1:0][SOFT_W-1:0]  d0_q;
    logic [CODE_N-1:0][SOFT_W-1:0]  d1_q;
    logic [NC*MW-1:0]               bm_n;
    logic [NC*MW-1:0]               bm_q;

    // An empty stage always loads, so bubbles collapse without waiting on out_ready.
    assign s2_load      = !v2 || bus.out_ready;
    assign s1_load      = !v1 || s2_load;
    assign bus.in_ready = s1_load;
    assign accept       = bus.in_valid && s1_load;
    assign tag          = bus.frame_start ? '0 : phase_cnt;

    always_comb begin
        keep = '0;
        for (int k = 0; k < PUNC_P; k++) begin
            if (tag == PW'(k)) keep = PUNC_MASK[k*CODE_N +: CODE_N];
        end
    end

    // Erased positions contribute nothing to any hypothesis.
    always_comb begin
        d0_n = '0;
        d1_n = '0;
        for (int i = 0; i < CODE_N; i++) begin
            if (keep[i]) begin
                d0_n[i] = bus.in_sym[i*SOFT_W +: SOFT_W];
                d1_n[i] = SMAX - bus.in_sym[i*SOFT_W +: SOFT_W];
            end
        end
    end

    always_comb begin
        bm_n = '0;
        for (int c = 0; c < NC; c++) begin
            for (int i = 0; i < CODE_N; i++) begin
                bm_n[c*MW +: MW] = bm_n[c*MW +: MW] + MW'(c[i] ? d1_q[i] : d0_q[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            ph1       <= '0;
            ph2       <= '0;
            d0_q      <= '0;
            d1_q      <= '0;
            bm_q      <= '0;
        end else begin
            if (accept) begin
                phase_cnt <= (tag == PH_LAST) ? '0 : tag + 1'b1;
                d0_q      <= d0_n;
                d1_q      <= d1_n;
                ph1       <= tag;
            end
            if (s1_load) v1 <= accept;
            if (s2_load) v2 <= v1;
            if (s2_load && v1) begin
                bm_q <= bm_n;
                ph2  <= ph1;
            end
        end
    end

    assign bus.out_valid = v2;
    assign bus.out_bm    = bm_q;
    assign bus.out_phase = ph2;
endmodule
